// File: rtl/serial_adder_if.sv
// serial_adder_if: handshake and data bundle for the bit-serial adder.
//   start, a, b, cin : request side, driven by the master
//   busy, done       : status, driven by the adder
//   sum, cout        : registered result, driven by the adder
interface serial_adder_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // Requester view: issues operands, observes status and result
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  // Adder view: receives operands, returns status and result
  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full-adder cell plus a carry flop.
// Captures a, b and cin on an accepted start, adds LSB-first one bit per
// clock, then updates sum/cout and pulses done for one cycle.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - serial_adder_if.slave (start/a/b/cin in, busy/done/sum/cout out)
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_adder_if.slave        bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] psum_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;

  logic             bit_s;
  logic             carry_nxt_s;
  logic [WIDTH-1:0] psum_nxt_s;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Full-adder cell on the current LSBs; new bit enters the partial sum at the MSB
  always_comb begin
    bit_s       = a_sh_r[0] ^ b_sh_r[0] ^ carry_r;
    carry_nxt_s = maj3(a_sh_r[0], b_sh_r[0], carry_r);
    psum_nxt_s  = psum_r >> 1'b1;
    psum_nxt_s[WIDTH-1] = bit_s;
  end

  // Control FSM and datapath registers; outputs are all registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      psum_r  <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_sh_r  <= bus.a;
            b_sh_r  <= bus.b;
            carry_r <= bus.cin;
            cnt_r   <= '0;
            psum_r  <= '0;
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          carry_r <= carry_nxt_s;
          a_sh_r  <= a_sh_r >> 1'b1;
          b_sh_r  <= b_sh_r >> 1'b1;
          psum_r  <= psum_nxt_s;
          cnt_r   <= cnt_r + CW'(1);
          if (cnt_r == CW'(WIDTH - 1)) begin
            // Final bit: publish the completed result together with done
            sum_r   <= psum_nxt_s;
            cout_r  <= carry_nxt_s;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= RUN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed-vector bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  int   busy_cnt;

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(1)) if1 ();

  serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
  serial_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one edge; adder must go busy
  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    if8.a = a; if8.b = b; if8.cin = cin; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    busy_cnt = 0;
    check_eq("start_busy", {31'd0, if8.busy}, 32'd1);
    check_eq("start_done", {31'd0, if8.done}, 32'd0);
    if (if8.busy) busy_cnt++;
  endtask

  // Run the remaining 8 edges; result must stay held until the done cycle
  task automatic finish8(input string tag, input logic [7:0] exp_sum, input logic exp_cout,
                         input logic [7:0] prev_sum, input logic prev_cout, input bit disturb);
    for (int i = 1; i < 8; i++) begin
      if (disturb) begin
        if8.a = ~if8.a;
        if8.b = if8.b + 8'd3;
        if8.cin = ~if8.cin;
        if8.start = (i == 3);
      end
      tick();
      if (!if8.busy || if8.done || if8.sum !== prev_sum || if8.cout !== prev_cout) begin
        check_eq({tag, "_run_busy"}, {31'd0, if8.busy}, 32'd1);
        check_eq({tag, "_run_done"}, {31'd0, if8.done}, 32'd0);
        check_eq({tag, "_held_sum"}, {24'd0, if8.sum}, {24'd0, prev_sum});
        check_eq({tag, "_held_cout"}, {31'd0, if8.cout}, {31'd0, prev_cout});
      end
      if (if8.busy) busy_cnt++;
    end
    if8.start = 1'b0;
    tick();
    check_eq({tag, "_done"}, {31'd0, if8.done}, 32'd1);
    check_eq({tag, "_busy_off"}, {31'd0, if8.busy}, 32'd0);
    check_eq({tag, "_busy_cycles"}, busy_cnt, 32'd8);
    check_eq({tag, "_sum"}, {24'd0, if8.sum}, {24'd0, exp_sum});
    check_eq({tag, "_cout"}, {31'd0, if8.cout}, {31'd0, exp_cout});
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; busy_cnt = 0;
    rst = 1'b1;
    if8.start = 1'b0; if8.a = 8'd0; if8.b = 8'd0; if8.cin = 1'b0;
    if1.start = 1'b0; if1.a = 1'b0; if1.b = 1'b0; if1.cin = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_busy", {31'd0, if8.busy}, 32'd0);
    check_eq("rst_done", {31'd0, if8.done}, 32'd0);
    check_eq("rst_sum", {24'd0, if8.sum}, 32'd0);
    check_eq("rst_cout", {31'd0, if8.cout}, 32'd0);
    check_eq("rst1_sum", {31'd0, if1.sum}, 32'd0);

    // 00+00+0
    start8(8'h00, 8'h00, 1'b0);
    finish8("zero", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    check_eq("zero_pulse_end", {31'd0, if8.done}, 32'd0);

    // 80+01+1 = 82, gives a non-zero value to hold
    start8(8'h80, 8'h01, 1'b1);
    finish8("c82", 8'h82, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();

    // FF+01+0 = 1_00, previous 0x82 held while running
    start8(8'hFF, 8'h01, 1'b0);
    finish8("ovf", 8'h00, 1'b1, 8'h82, 1'b0, 1'b0);
    tick();

    // A5+5A+1 = 1_00, then back-to-back 3C+42+0 = 7E with start during DONE
    start8(8'hA5, 8'h5A, 1'b1);
    finish8("a55a", 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    start8(8'h3C, 8'h42, 1'b0);
    finish8("b2b", 8'h7E, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    check_eq("b2b_pulse_end", {31'd0, if8.done}, 32'd0);

    // 99+66+0 = FF, operands and start disturbed while running
    start8(8'h99, 8'h66, 1'b0);
    finish8("dist", 8'hFF, 1'b0, 8'h7E, 1'b0, 1'b1);
    tick();
    check_eq("dist_no_restart", {31'd0, if8.busy}, 32'd0);

    // Reset at edge k+4 mid-run
    start8(8'hFF, 8'hFF, 1'b1);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort_busy", {31'd0, if8.busy}, 32'd0);
    check_eq("abort_done", {31'd0, if8.done}, 32'd0);
    check_eq("abort_sum", {24'd0, if8.sum}, 32'd0);
    check_eq("abort_cout", {31'd0, if8.cout}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (if8.done || if8.busy) check_eq("abort_no_done", {30'd0, if8.busy, if8.done}, 32'd0);
    end
    start8(8'h12, 8'h34, 1'b1);
    finish8("post_rst", 8'h47, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();

    // WIDTH=1 half-adder truth table
    for (int v = 0; v < 4; v++) begin
      logic [1:0] ab;
      logic [1:0] exp_sc;
      ab = v[1:0];
      case (ab)
        2'b00:   exp_sc = 2'b00;
        2'b01:   exp_sc = 2'b10;
        2'b10:   exp_sc = 2'b10;
        default: exp_sc = 2'b01;
      endcase
      if1.a = ab[1]; if1.b = ab[0]; if1.cin = 1'b0; if1.start = 1'b1;
      tick();
      if1.start = 1'b0;
      check_eq("w1_busy", {30'd0, if1.busy, if1.done}, 32'd2);
      tick();
      check_eq("w1_done", {30'd0, if1.busy, if1.done}, 32'd1);
      check_eq("w1_sum_cout", {30'd0, if1.sum, if1.cout}, {30'd0, exp_sc});
      tick();
      check_eq("w1_pulse_end", {31'd0, if1.done}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
